obi_mem_responder: RTL

- Parametrised memory-side responder for the formal and simulation harnesses around the core; it replaces free-running grant/valid inputs on the instruction and data ports.
- Drives NUM_CH independent OBI-style channels (gnt/rvalid/rdata). It takes free random stimulus (formal rand regs or bench LFSR) and turns it into protocol-legal responses.
- Enforces no grant without request, bounded grant and response latency, an outstanding-transaction limit and in-order responses.
- Includes a per-channel requester-side protocol checker with a sticky error flag.

---
 rtl/obi_mem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/obi_mem_responder.sv
// Memory-side OBI responder: turns free random stimulus into legal gnt/rvalid/rdata per channel,
// with bounded stalls, an outstanding limit, in-order responses and a sticky requester checker.
module obi_mem_responder #(
    parameter int NUM_CH           = 2,
    parameter int DW               = 32,
    parameter int MAX_OUTSTANDING  = 2,
    parameter int MAX_GNT_STALL    = 3,
    parameter int MAX_RVALID_STALL = 3,
    parameter int RDATA_MODE       = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [NUM_CH*DW-1:0] addr_i,
    input  logic [NUM_CH-1:0]    we_i,
    input  logic [NUM_CH-1:0]    rand_gnt_i,
    input  logic [NUM_CH-1:0]    rand_rvalid_i,
    input  logic [NUM_CH*DW-1:0] rand_rdata_i,
    output logic [NUM_CH-1:0]    gnt_o,
    output logic [NUM_CH-1:0]    rvalid_o,
    output logic [NUM_CH*DW-1:0] rdata_o,
    output logic [NUM_CH*4-1:0]  outstanding_o,
    output logic [NUM_CH-1:0]    err_o
);

    localparam int GW = (MAX_GNT_STALL > 0) ? $clog2(MAX_GNT_STALL + 1) : 1;
    localparam int RW = (MAX_RVALID_STALL > 0) ? $clog2(MAX_RVALID_STALL + 1) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [3:0]    cnt_q, cnt_d;
        logic [GW-1:0] gstall_q, gstall_d;
        logic [RW-1:0] rstall_q, rstall_d;
        logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
        logic [DW:0]   fifo_q [MAX_OUTSTANDING];
        logic [DW:0]   head;
        logic          pend_q, prev_we_q, err_q, viol;
        logic [DW-1:0] prev_addr_q, addr;
        logic          req, we, gnt, rvalid, full;

        assign req  = req_i[c];
        assign we   = we_i[c];
        assign addr = addr_i[c*DW +: DW];
        assign head = fifo_q[rptr_q];

        // Full looks only at the registered count: a same-cycle response never frees a slot.
        assign full   = cnt_q >= 4'(MAX_OUTSTANDING);
        assign gnt    = rst_ni & req & ~full &
                        (rand_gnt_i[c] | (gstall_q == GW'(MAX_GNT_STALL)));
        assign rvalid = rst_ni & (|cnt_q) &
                        (rand_rvalid_i[c] | (rstall_q == RW'(MAX_RVALID_STALL)));

        // A stalled request must be held with identical address and direction.
        assign viol = pend_q & (~req | (addr != prev_addr_q) | (we != prev_we_q));

        always_comb begin
            cnt_d    = cnt_q;
            gstall_d = gstall_q;
            rstall_d = rstall_q;
            wptr_d   = wptr_q;
            rptr_d   = rptr_q;
            if (gnt && !rvalid) begin
                cnt_d = cnt_q + 4'd1;
            end else if (!gnt && rvalid) begin
                cnt_d = cnt_q - 4'd1;
            end
            if (!req || gnt) begin
                gstall_d = '0;
            end else if (gstall_q != GW'(MAX_GNT_STALL)) begin
                gstall_d = gstall_q + GW'(1);
            end
            if (!(|cnt_q) || rvalid) begin
                rstall_d = '0;
            end else if (rstall_q != RW'(MAX_RVALID_STALL)) begin
                rstall_d = rstall_q + RW'(1);
            end
            if (gnt) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (rvalid) begin
                rptr_d = ptr_inc(rptr_q);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q       <= '0;
                gstall_q    <= '0;
                rstall_q    <= '0;
                wptr_q      <= '0;
                rptr_q      <= '0;
                pend_q      <= 1'b0;
                prev_addr_q <= '0;
                prev_we_q   <= 1'b0;
                err_q       <= 1'b0;
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    fifo_q[i] <= '0;
                end
            end else begin
                cnt_q       <= cnt_d;
                gstall_q    <= gstall_d;
                rstall_q    <= rstall_d;
                wptr_q      <= wptr_d;
                rptr_q      <= rptr_d;
                pend_q      <= req & ~gnt;
                prev_addr_q <= addr;
                prev_we_q   <= we;
                err_q       <= err_q | viol;
                if (gnt) begin
                    fifo_q[wptr_q] <= {we, addr};
                end
            end
        end

        assign gnt_o[c]              = gnt;
        assign rvalid_o[c]           = rvalid;
        assign err_o[c]              = err_q;
        assign outstanding_o[c*4 +: 4] = cnt_q;
        // Write responses carry no data in either mode.
        assign rdata_o[c*DW +: DW]   = (!rvalid || head[DW]) ? '0 :
                                       (RDATA_MODE != 0) ? head[DW-1:0] :
                                       rand_rdata_i[c*DW +: DW];
    end

endmodule
